// File: rtl/frac_reduce.sv
// Reduces a/b by an upstream gcd g using restoring division; result 2*WIDTH+1 cycles after gcd accept
// (WIDTH+1 when FRAC_REDUCE_PARALLEL_EN is defined, 1 when g==0). No backpressure: valid_i restarts at once.
module frac_reduce #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] gcd_i,
  input  logic             gcd_valid_i,
  output logic [WIDTH-1:0] num_o,
  output logic [WIDTH-1:0] den_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef FRAC_REDUCE_PARALLEL_EN
  typedef enum logic [2:0] {IDLE, WAIT_GCD, DIV, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_GCD, DIV_A, DIV_B, DONE} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_g;
  logic [WIDTH-1:0]   r_rem_a;
  logic [WIDTH-1:0]   r_quo_a;
  logic [WIDTH-1:0]   r_num;
  logic [WIDTH-1:0]   r_den;
  logic [CW-1:0]      r_cnt;
  logic               w_last;
  logic [2*WIDTH-1:0] w_step_a;
`ifdef FRAC_REDUCE_PARALLEL_EN
  logic [WIDTH-1:0]   r_rem_b;
  logic [WIDTH-1:0]   r_quo_b;
  logic [2*WIDTH-1:0] w_step_b;
`else
  logic [WIDTH-1:0]   r_qa;
`endif

  // One restoring step: the quotient register doubles as the dividend shifter.
  // The trial remainder is WIDTH+1 bits; after restore it always fits in WIDTH bits.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             neg;
    sh   = {rem, quo[WIDTH-1]};
    diff = {1'b0, sh} - {2'b00, g};
    neg  = diff[WIDTH+1];
    div_step = {(neg ? WIDTH'(sh) : WIDTH'(diff)), quo[WIDTH-2:0], ~neg};
  endfunction

  assign w_step_a = div_step(r_rem_a, r_quo_a, r_g);
`ifdef FRAC_REDUCE_PARALLEL_EN
  assign w_step_b = div_step(r_rem_b, r_quo_b, r_g);
`endif
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid_i) begin
      w_state_nxt = WAIT_GCD;
    end else begin
      case (r_state)
        IDLE:     w_state_nxt = IDLE;
`ifdef FRAC_REDUCE_PARALLEL_EN
        WAIT_GCD: if (gcd_valid_i) w_state_nxt = (gcd_i == '0) ? DONE : DIV;
        DIV:      if (w_last) w_state_nxt = DONE;
`else
        WAIT_GCD: if (gcd_valid_i) w_state_nxt = (gcd_i == '0) ? DONE : DIV_A;
        DIV_A:    if (w_last) w_state_nxt = DIV_B;
        DIV_B:    if (w_last) w_state_nxt = DONE;
`endif
        DONE:     w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_g     <= '0;
      r_rem_a <= '0;
      r_quo_a <= '0;
      r_num   <= '0;
      r_den   <= '0;
      r_cnt   <= '0;
`ifdef FRAC_REDUCE_PARALLEL_EN
      r_rem_b <= '0;
      r_quo_b <= '0;
`else
      r_qa    <= '0;
`endif
    end else if (valid_i) begin
      r_a <= a_i;
      r_b <= b_i;
    end else begin
      case (r_state)
        WAIT_GCD: begin
          if (gcd_valid_i) begin
            r_g     <= gcd_i;
            r_cnt   <= '0;
            r_rem_a <= '0;
            r_quo_a <= r_a;
`ifdef FRAC_REDUCE_PARALLEL_EN
            r_rem_b <= '0;
            r_quo_b <= r_b;
`endif
            if (gcd_i == '0) begin
              r_num <= '0;
              r_den <= '0;
            end
          end
        end
`ifdef FRAC_REDUCE_PARALLEL_EN
        DIV: begin
          {r_rem_a, r_quo_a} <= w_step_a;
          {r_rem_b, r_quo_b} <= w_step_b;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_num <= w_step_a[WIDTH-1:0];
            r_den <= w_step_b[WIDTH-1:0];
          end
        end
`else
        DIV_A: begin
          {r_rem_a, r_quo_a} <= w_step_a;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Park the numerator quotient and reload the shared divider with b.
            r_qa    <= w_step_a[WIDTH-1:0];
            r_rem_a <= '0;
            r_quo_a <= r_b;
            r_cnt   <= '0;
          end
        end
        DIV_B: begin
          {r_rem_a, r_quo_a} <= w_step_a;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_num <= r_qa;
            r_den <= w_step_a[WIDTH-1:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign num_o   = r_num;
  assign den_o   = r_den;
  assign valid_o = (r_state == DONE);
  assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_frac_reduce.sv
// Bench for frac_reduce: directed corner cases plus random pairs checked against an arithmetic model.
module tb_frac_reduce;
  localparam int W = 8;
`ifdef FRAC_REDUCE_PARALLEL_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = 2 * W + 1;
`endif

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b1;
  logic         valid_i = 1'b0;
  logic         gcd_valid_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] gcd_i = '0;
  logic [W-1:0] num_o;
  logic [W-1:0] den_o;
  logic         valid_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  frac_reduce #(.WIDTH(W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .gcd_i(gcd_i), .gcd_valid_i(gcd_valid_i), .num_o(num_o), .den_o(den_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void ref_frac(input int a, input int b, input int g,
                                   output int n, output int d, output int lat);
    if (g == 0) begin
      n = 0; d = 0; lat = 1;
    end else begin
      n = a / g; d = b / g; lat = LAT;
    end
  endfunction

  // Launches one pair and its gcd on the following cycle; returns what the DUT produced.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                        output int lat, output logic [W-1:0] num, output logic [W-1:0] den,
                        output logic v_after, output logic b_after);
    @(posedge clk_i); #1; valid_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk_i); #1; valid_i = 1'b0; gcd_valid_i = 1'b1; gcd_i = g;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0; lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); #1; lat++;
    end
    num = num_o; den = den_o;
    @(posedge clk_i); #1; v_after = valid_o; b_after = busy_o;
  endtask

  task automatic test_reset();
    #3 reset_ni = 1'b0;
    #2;
    checks++; if (num_o !== 8'd0) begin errors++; $display("FAIL reset_num got %0d want 0", num_o); end
    checks++; if (den_o !== 8'd0) begin errors++; $display("FAIL reset_den got %0d want 0", den_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    @(negedge clk_i); reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy_o); end
  endtask

  task automatic test_directed();
    int ta [5] = '{18, 0, 255, 0, 20};
    int tb [5] = '{12, 5, 255, 0, 8};
    int tg [5] = '{6, 5, 255, 0, 4};
    int lat, en, ed, el;
    logic [W-1:0] n, d;
    logic va, ba;
    for (int i = 0; i < 5; i++) begin
      run_op(W'(ta[i]), W'(tb[i]), W'(tg[i]), lat, n, d, va, ba);
      ref_frac(ta[i], tb[i], tg[i], en, ed, el);
      checks++; if (lat != el) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el); end
      checks++; if (n !== W'(en)) begin errors++; $display("FAIL dir%0d_num got %0d want %0d", i, n, en); end
      checks++; if (d !== W'(ed)) begin errors++; $display("FAIL dir%0d_den got %0d want %0d", i, d, ed); end
      checks++; if (va !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse valid=%b busy=%b want 0 0", i, va, ba); end
    end
  endtask

  // Last directed result was 20/8 by 4 -> 5/2; a new valid_i must not disturb it.
  task automatic test_hold();
    int lat;
    @(posedge clk_i); #1; valid_i = 1'b1; a_i = 8'd100; b_i = 8'd50;
    @(posedge clk_i); #1; valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (num_o !== 8'd5 || den_o !== 8'd2) begin errors++; $display("FAIL hold got %0d/%0d want 5/2", num_o, den_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", busy_o); end
    gcd_valid_i = 1'b1; gcd_i = 8'd50;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0; lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); #1; lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat, LAT); end
    checks++; if (num_o !== 8'd2 || den_o !== 8'd1) begin errors++; $display("FAIL hold_result got %0d/%0d want 2/1", num_o, den_o); end
  endtask

  task automatic test_gcd_ignore();
    int lat, pulses;
    @(posedge clk_i); #1; gcd_valid_i = 1'b1; gcd_i = 8'd4;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL gcd_idle_busy got %b want 0", busy_o); end
    valid_i = 1'b1; a_i = 8'd8; b_i = 8'd4; gcd_valid_i = 1'b1; gcd_i = 8'd4;
    @(posedge clk_i); #1; valid_i = 1'b0; gcd_valid_i = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL gcd_same_cycle_pulses got %0d want 0", pulses); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL gcd_same_cycle_busy got %b want 1", busy_o); end
    gcd_valid_i = 1'b1; gcd_i = 8'd4;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0; lat = 1;
    // A stray gcd strobe mid-division must be ignored.
    while (valid_o !== 1'b1 && lat < 100) begin
      gcd_valid_i = (lat == 4); gcd_i = 8'd2;
      @(posedge clk_i); #1; lat++;
    end
    gcd_valid_i = 1'b0;
    checks++; if (lat != LAT) begin errors++; $display("FAIL gcd_ignore_latency got %0d want %0d", lat, LAT); end
    checks++; if (num_o !== 8'd2 || den_o !== 8'd1) begin errors++; $display("FAIL gcd_ignore_result got %0d/%0d want 2/1", num_o, den_o); end
  endtask

  task automatic test_abort();
    int pulses, first, lat;
    logic [W-1:0] n, d;
    pulses = 0; first = 0; n = '0; d = '0;
    @(posedge clk_i); #1; valid_i = 1'b1; a_i = 8'd18; b_i = 8'd12;
    @(posedge clk_i); #1; valid_i = 1'b0; gcd_valid_i = 1'b1; gcd_i = 8'd6;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) pulses++;
    end
    valid_i = 1'b1; a_i = 8'd9; b_i = 8'd12;
    @(posedge clk_i); #1; valid_i = 1'b0; gcd_valid_i = 1'b1; gcd_i = 8'd3;
    if (valid_o === 1'b1) pulses++;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0; lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (valid_o === 1'b1) begin
        pulses++;
        if (first == 0) begin first = lat; n = num_o; d = den_o; end
      end
      @(posedge clk_i); #1; lat++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", pulses); end
    checks++; if (first != LAT) begin errors++; $display("FAIL abort_latency got %0d want %0d", first, LAT); end
    checks++; if (n !== 8'd3 || d !== 8'd4) begin errors++; $display("FAIL abort_result got %0d/%0d want 3/4", n, d); end
  endtask

  task automatic test_back_to_back();
    int a, b, g, en, ed, el, lat;
    logic [W-1:0] n, d;
    logic va, ba;
    for (int i = 0; i < 24; i++) begin
      g = (i % 8 == 7) ? 0 : $urandom_range(1, 255);
      if (i % 2 == 0 && g != 0) begin
        a = g * $urandom_range(0, 255 / g);
        b = g * $urandom_range(1, 255 / g);
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
      end
      run_op(W'(a), W'(b), W'(g), lat, n, d, va, ba);
      ref_frac(a, b, g, en, ed, el);
      checks++;
      if (lat != el || n !== W'(en) || d !== W'(ed) || va !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d a=%0d b=%0d g=%0d got lat=%0d %0d/%0d after=%b want lat=%0d %0d/%0d after=0",
                 i, a, b, g, lat, n, d, va, el, en, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [W-1:0] n, d;
    logic va, ba;
    run_op(8'd18, 8'd12, 8'd6, lat, n, d, va, ba);
    checks++; if (n !== 8'd3 || d !== 8'd2) begin errors++; $display("FAIL rmid_pre got %0d/%0d want 3/2", n, d); end
    @(posedge clk_i); #1; valid_i = 1'b1; a_i = 8'd18; b_i = 8'd12;
    @(posedge clk_i); #1; valid_i = 1'b0; gcd_valid_i = 1'b1; gcd_i = 8'd6;
    @(posedge clk_i); #1; gcd_valid_i = 1'b0;
    repeat (11) @(posedge clk_i);
    #3 reset_ni = 1'b0;
    #1;
    checks++; if (num_o !== 8'd0 || den_o !== 8'd0) begin errors++; $display("FAIL rmid_out got %0d/%0d want 0/0", num_o, den_o); end
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL rmid_ctrl busy=%b valid=%b want 0 0", busy_o, valid_o); end
    @(negedge clk_i); reset_ni = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1 || busy_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_after got %0d active cycles want 0", pulses); end
    checks++; if (num_o !== 8'd0 || den_o !== 8'd0) begin errors++; $display("FAIL rmid_hold got %0d/%0d want 0/0", num_o, den_o); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_gcd_ignore();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frac_reduce.md
FRAC_REDUCE -- requirements
Module: frac_reduce

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 reset_ni  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  new operand pair present; same strobe that launches the upstream gcd.
REQ-005 a_i, b_i  input  WIDTH each  numerator / denominator operands.
REQ-006 gcd_i  input  WIDTH  gcd result from upstream gcd stage.
REQ-007 gcd_valid_i  input  1  gcd_i valid strobe from upstream.
REQ-008 num_o, den_o  output  WIDTH each  reduced numerator a/g and denominator b/g.
REQ-009 valid_o  output  1  one-cycle pulse, num_o/den_o valid.
REQ-010 busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 States: IDLE, WAIT_GCD, DIV_A, DIV_B, DONE; single-cycle transitions on clk_i.
REQ-012 valid_i=1 in any state: capture a_i, b_i, clear valid_o, go to WAIT_GCD (abort any division in progress).
REQ-013 valid_i has priority over gcd_valid_i when both high in the same cycle.
REQ-014 WAIT_GCD with gcd_valid_i=1: capture gcd_i as divisor g; if g==0 go to DONE with num_o=0, den_o=0; else go to DIV_A.
REQ-015 gcd_valid_i outside WAIT_GCD: ignored, no state change.
REQ-016 DIV_A: restoring unsigned division a/g, one quotient bit per cycle MSB first, exactly WIDTH cycles, remainder WIDTH+1 bits wide; then DIV_B.
REQ-017 DIV_B: same algorithm for b/g, exactly WIDTH cycles; then DONE.
REQ-018 Quotients written to num_o/den_o on entry to DONE; remainders discarded (zero by construction, not checked).
REQ-019 DONE: valid_o=1 for exactly one cycle, next state IDLE.
REQ-020 Latency gcd_valid_i accepted -> valid_o high: 2*WIDTH+1 cycles (g!=0); 1 cycle (g==0).
REQ-021 num_o/den_o hold last result until the next DONE or reset; valid_i does not clear them.
REQ-022 a_i=0 with g=b: num_o=0, den_o=1; a==b!=0: num_o=1, den_o=1.
REQ-023 No arithmetic overflow possible: quotient never exceeds WIDTH bits since g>=1.

Reset
REQ-024 reset_ni=0 asserts immediately regardless of clk_i: state IDLE, num_o=0, den_o=0, valid_o=0, busy_o=0, internal registers 0.
REQ-025 Reset during any division aborts it; no valid_o after release until a new valid_i/gcd_valid_i sequence.
REQ-026 First edge after reset_ni rises behaves as from IDLE.

Configuration
REQ-027 Macro FRAC_REDUCE_PARALLEL_EN defined: DIV_A and DIV_B merged into one DIV state dividing a and b concurrently with two dividers; latency 2*WIDTH+1 becomes WIDTH+1.
REQ-028 Macro undefined: single shared divider, sequential DIV_A then DIV_B per REQ-016/017; results identical in both builds.

Verification
REQ-029 WIDTH=8, valid_i with a=18,b=12, gcd_valid_i g=6 next cycle -> valid_o 17 cycles after gcd accept, num_o=3, den_o=2 (9 cycles with PARALLEL_EN).
REQ-030 a=0,b=5,g=5 -> num_o=0, den_o=1; a=255,b=255,g=255 -> num_o=1, den_o=1.
REQ-031 a=0,b=0,g=0 -> valid_o 1 cycle after gcd accept, num_o=0, den_o=0.
REQ-032 a=18,b=12 started, new valid_i a=9,b=12 during DIV_A, then g=3 -> single valid_o, num_o=3, den_o=4; no result for first pair.
REQ-033 reset_ni low mid-DIV_B (asynchronous, between edges) -> outputs 0 immediately, busy_o=0, no valid_o afterwards without new stimulus.
REQ-034 gcd_valid_i pulsed while IDLE and again in same cycle as valid_i -> both ignored, state WAIT_GCD after second.
